// File: rtl/ibf_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ibf_pipe_pkg
// Shared constants and helpers for the inverse-butterfly datapath.
//   NBITS_DEF / CNT_W_DEF : default recovered-component width and error
//                           counter width.
//   comp_lsb()            : LSB offset of a component inside a packed
//                           {re,im} word (real in the upper half).
//   sat_max() / sat_min() : signed saturation limits for an n-bit result.
// ---------------------------------------------------------------------------
package ibf_pipe_pkg;

    localparam int NBITS_DEF = 10;
    localparam int CNT_W_DEF = 8;

    localparam int COMP_RE = 0;
    localparam int COMP_IM = 1;

    // Packed words are {re, im}; each field is w bits wide.
    function automatic int comp_lsb(input int comp, input int w);
        return (comp == COMP_RE) ? w : 0;
    endfunction

    function automatic int sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage

// File: rtl/ibf_pipe_if.sv
// ---------------------------------------------------------------------------
// ibf_pipe_if
// Streaming bus of the inverse butterfly.
//   IBFIn_up/IBFIn_down   : input pair, {re,im}, NBITS+1 bits per component
//   in_valid / in_ready   : input handshake
//   IBFOut_up/IBFOut_down : recovered a / b, {re,im}, NBITS bits per component
//   out_valid / out_ready : output handshake
//   sat_flag, parity_err  : status qualified by out_valid
//   err_cnt               : saturating parity-error count
// Modports: master = pair source / result sink, slave = the ibf_pipe block.
// ---------------------------------------------------------------------------
interface ibf_pipe_if
    import ibf_pipe_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [2*(NBITS+1)-1:0] IBFIn_up;
    logic [2*(NBITS+1)-1:0] IBFIn_down;
    logic                   in_valid;
    logic                   in_ready;
    logic [2*NBITS-1:0]     IBFOut_up;
    logic [2*NBITS-1:0]     IBFOut_down;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sat_flag;
    logic                   parity_err;
    logic [CNT_W-1:0]       err_cnt;

    modport master (
        output IBFIn_up, IBFIn_down, in_valid, out_ready,
        input  in_ready, IBFOut_up, IBFOut_down, out_valid,
               sat_flag, parity_err, err_cnt
    );

    modport slave (
        input  IBFIn_up, IBFIn_down, in_valid, out_ready,
        output in_ready, IBFOut_up, IBFOut_down, out_valid,
               sat_flag, parity_err, err_cnt
    );
endinterface

// File: rtl/ibf_pipe_sat.sv
// ---------------------------------------------------------------------------
// ibf_sat
// Signed saturator, NBITS+1 -> NBITS bits, with overflow flag.
//   i_din  : signed NBITS+1 input
//   o_dout : input clamped to [sat_min(NBITS), sat_max(NBITS)]
//   o_ovf  : high when clamping occurred
// ---------------------------------------------------------------------------
module ibf_sat
    import ibf_pipe_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic signed [NBITS:0]   i_din,
    output logic signed [NBITS-1:0] o_dout,
    output logic                    o_ovf
);
    localparam logic signed [NBITS-1:0] MAX_V = NBITS'(sat_max(NBITS));
    localparam logic signed [NBITS-1:0] MIN_V = NBITS'(sat_min(NBITS));

    always_comb begin
        // Value fits in NBITS exactly when the two top bits agree.
        o_ovf  = i_din[NBITS] ^ i_din[NBITS-1];
        o_dout = i_din[NBITS-1:0];
        if (o_ovf) begin
            o_dout = i_din[NBITS] ? MIN_V : MAX_V;
        end
    end
endmodule

// File: rtl/ibf_pipe.sv
// ---------------------------------------------------------------------------
// ibf_pipe
// Inverse radix-2 butterfly: from up=a+b, down=a-b recovers
//   a = (up+down)>>>1, b = (up-down)>>>1, each saturated to NBITS bits.
// Two-stage pipeline (S1: add/sub, S2: halve + saturate) with valid/ready
// handshake, full throughput and a 2-cycle accept-to-valid latency.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ibf_pipe_if.slave (pair in, result out, status, error counter)
// Configuration macro: IBF_PARITY_CHK_EN
//   defined   -> per-component LSB parity check of up/down, parity_err flag
//                travels with its pair, err_cnt counts flagged output
//                transfers and saturates at all-ones.
//   undefined -> parity_err and err_cnt are constant 0.
// ---------------------------------------------------------------------------
module ibf_pipe
    import ibf_pipe_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    ibf_pipe_if.slave bus
);
    localparam int IW = NBITS + 1;   // input component width
    localparam int SW = NBITS + 2;   // sum/difference width

    logic signed [IW-1:0]    w_u [2];
    logic signed [IW-1:0]    w_d [2];
    logic signed [SW-1:0]    w_s [2];
    logic signed [SW-1:0]    w_t [2];
    logic signed [SW-1:0]    r_s [2];
    logic signed [SW-1:0]    r_t [2];
    // Index = 2*component + {0: sum -> a, 1: difference -> b}
    logic signed [IW-1:0]    w_half [4];
    logic signed [NBITS-1:0] w_sat  [4];
    logic signed [NBITS-1:0] r_out  [4];
    logic [3:0]              w_ovf;

    logic r_s1_v;
    logic r_s2_v;
    logic r_sat;
    logic w_s1_load;
    logic w_s2_load;

    // S2 may take new data when empty or when its content leaves this cycle;
    // S1 may load when empty or when it hands its pair to S2.
    assign w_s2_load    = ~r_s2_v | bus.out_ready;
    assign w_s1_load    = ~r_s1_v | w_s2_load;
    assign bus.in_ready = w_s1_load;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
            assign w_u[gi] = bus.IBFIn_up  [comp_lsb(gi, IW) +: IW];
            assign w_d[gi] = bus.IBFIn_down[comp_lsb(gi, IW) +: IW];
            assign w_s[gi] = SW'(w_u[gi]) + SW'(w_d[gi]);
            assign w_t[gi] = SW'(w_u[gi]) - SW'(w_d[gi]);
            // Arithmetic shift floors odd values toward -inf.
            assign w_half[2*gi]   = IW'(r_s[gi] >>> 1);
            assign w_half[2*gi+1] = IW'(r_t[gi] >>> 1);
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_sat
            ibf_sat #(.NBITS(NBITS)) u_sat (
                .i_din  (w_half[gi]),
                .o_dout (w_sat[gi]),
                .o_ovf  (w_ovf[gi])
            );
        end
    endgenerate

    // S1 datapath registers carry no reset: they are only observed behind r_s1_v.
    always_ff @(posedge clk) begin
        if (w_s1_load && bus.in_valid) begin
            r_s <= w_s;
            r_t <= w_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_sat  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            if (w_s1_load) begin
                r_s1_v <= bus.in_valid;
            end
            if (w_s2_load) begin
                r_s2_v <= r_s1_v;
                // Outputs keep their last value while no new pair arrives.
                if (r_s1_v) begin
                    r_out <= w_sat;
                    r_sat <= |w_ovf;
                end
            end
        end
    end

    assign bus.IBFOut_up   = {r_out[0], r_out[2]};
    assign bus.IBFOut_down = {r_out[1], r_out[3]};
    assign bus.out_valid   = r_s2_v;
    assign bus.sat_flag    = r_sat;

`ifdef IBF_PARITY_CHK_EN
    logic             w_par;
    logic             w_out_fire;
    logic             r_s1_par;
    logic             r_par;
    logic [CNT_W-1:0] r_err_cnt;

    // a+b and a-b always share parity, so differing LSBs mean a corrupt pair.
    assign w_par      = (w_u[0][0] ^ w_d[0][0]) | (w_u[1][0] ^ w_d[1][0]);
    assign w_out_fire = r_s2_v & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_par  <= 1'b0;
            r_par     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_s1_load && bus.in_valid) begin
                r_s1_par <= w_par;
            end
            if (w_s2_load && r_s1_v) begin
                r_par <= r_s1_par;
            end
            if (w_out_fire && r_par && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.parity_err = r_par;
    assign bus.err_cnt    = r_err_cnt;
`else
    assign bus.parity_err = 1'b0;
    assign bus.err_cnt    = {CNT_W{1'b0}};
`endif

endmodule
